ram_bist: RTL and testbench
===========================

RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 21, meaning the memory word-address width (bank select bit plus 20-bit SRAM address).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width.
REQ-003 The block SHALL have parameter ERR_WIDTH, default 16, meaning the error-counter width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for one driver response.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports: clk  in  1  system clock; rst  in  1  synchronous active-low reset.
REQ-006 The block SHALL have the following control ports: start  in  1  level, rising edge launches a test; mode  in  2  pattern select; addr_lo  in  ADDR_WIDTH  first address; addr_hi  in  ADDR_WIDTH  last address, inclusive.
REQ-007 The block SHALL have the following status ports: busy  out  1  test running; done  out  1  one-cycle pulse at test end; pass  out  1  last result; timeout_err  out  1  last test aborted on timeout; err_count  out  ERR_WIDTH  mismatches, saturating; first_err_addr  out  ADDR_WIDTH  address of first mismatch; first_err_data  out  DATA_WIDTH  word read at first mismatch.
REQ-008 The block SHALL have the following driver-side ports: mem_read_req  out  1  one-cycle read pulse; mem_write_req  out  1  one-cycle write pulse; mem_addr  out  ADDR_WIDTH  request address; mem_wdata  out  DATA_WIDTH  write data; mem_rdata  in  DATA_WIDTH  read data; mem_write_done  in  1  write complete pulse; mem_read_ready  in  1  read data valid pulse.

Function
REQ-009 The start input SHALL be edge-detected with a registered copy, and a rising edge while busy=1 SHALL be ignored.
REQ-010 The FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK and FINISH.
REQ-011 A start edge sampled at cycle N in IDLE SHALL give busy=1 and state WR_REQ at N+1, SHALL clear err_count, pass, timeout_err and first_err_*, and SHALL latch mode, addr_lo and addr_hi.
REQ-012 If the latched addr_lo > addr_hi, the FSM SHALL go directly to FINISH with pass=0 and timeout_err=0.
REQ-013 Write phase: WR_REQ SHALL assert mem_write_req for exactly one cycle with mem_addr=cur_addr and mem_wdata=pattern(cur_addr), then go to WR_WAIT.
REQ-014 WR_WAIT SHALL advance on mem_write_done: to the next address via WR_REQ, or, after addr_hi, to RD_REQ with cur_addr reset to addr_lo.
REQ-015 Read phase: RD_REQ SHALL assert mem_read_req for one cycle; RD_WAIT SHALL register mem_rdata on mem_read_ready; CHECK SHALL compare the registered data with pattern(cur_addr) in the following cycle.
REQ-016 On mismatch, err_count SHALL increment and saturate at all-ones, and first_err_addr/first_err_data SHALL be loaded only when err_count was 0.
REQ-017 After addr_hi is checked, the FSM SHALL enter FINISH, SHALL set pass=(err_count==0 and no timeout), SHALL pulse done for one cycle, and SHALL return to IDLE with busy=0 on the next cycle.
REQ-018 Response pulses (mem_write_done, mem_read_ready) SHALL be sampled only in WR_WAIT and RD_WAIT, and SHALL be ignored in all other states.
REQ-019 A wait counter SHALL clear on entry to each WAIT state; if it reaches TIMEOUT without a response, the FSM SHALL go to FINISH with timeout_err=1 and pass=0.
REQ-020 Address increment SHALL terminate on equality with addr_hi, not on wrap; addr_hi = all-ones SHALL complete without cur_addr wrapping to 0.
REQ-021 pattern(a) SHALL be selected by mode as follows:
- 0: a zero-extended or truncated to DATA_WIDTH.
- 1: bitwise inverse of the mode-0 pattern.
- 2: all-0x5 nibbles when a[0]=0, all-0xA nibbles when a[0]=1.
- 3: walking one, with only bit (a mod DATA_WIDTH) set.
REQ-022 mem_addr and mem_wdata SHALL be registered and stable from the request cycle through the end of the matching WAIT state.
REQ-023 Status outputs (pass, timeout_err, err_count, first_err_*) SHALL hold their values until the next accepted start.

Reset
REQ-024 With rst=0 at a clock edge, the state SHALL be IDLE, and busy, done, pass, timeout_err, mem_read_req and mem_write_req SHALL be 0.
REQ-025 With rst=0 at a clock edge, err_count, first_err_addr, first_err_data, mem_addr, mem_wdata, cur_addr and the wait counter SHALL be 0, and the start edge register SHALL be 0.
REQ-026 Reset asserted mid-test SHALL abort within one cycle, with no further request pulses and no done pulse.

Structure
REQ-027 FSM state encodings and mode codes SHALL be defined as constants in a shared ram_pkg package, alongside the ram_driver constants.
REQ-028 Pattern generation SHALL be a combinational sub-module, ram_pattern_gen (parameters ADDR_WIDTH, DATA_WIDTH; inputs mode and addr; output data), instantiated twice: once for write data and once for the expected value.

Verification
REQ-029 Zero-latency-ish model (1-cycle responses), mode=0, addr_lo=0x10, addr_hi=0x13 -> 4 writes of data 0x10..0x13, 4 reads, done pulse, pass=1, err_count=0.
REQ-030 Model corrupting the read at 0x12 to 0xDEAD, mode=1 -> err_count=1, first_err_addr=0x12, first_err_data=0xDEAD, pass=0.
REQ-031 Model that never returns mem_read_ready, TIMEOUT=255 -> timeout_err=1 and pass=0 at 256 cycles after RD_REQ, with no further requests.
REQ-032 addr_lo=0x1FFFFE, addr_hi=0x1FFFFF, mode=3 -> exactly 2 writes and 2 reads, wdata bits 30 and 31 set respectively, no wrap, pass=1.
REQ-033 addr_lo=5, addr_hi=4 -> done pulse 2 cycles after the start edge, with pass=0 and no request pulses.
REQ-034 rst=0 applied during WR_WAIT -> busy=0 next cycle, with no done pulse; a later start gives a clean full run with pass=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the RAM driver and its built-in self-test controller.
package ram_pkg;

  // BIST controller state encodings
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrWait = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdWait = 3'd4;
  localparam logic [2:0] StCheck  = 3'd5;
  localparam logic [2:0] StFinish = 3'd6;

  // Test pattern select codes
  localparam logic [1:0] ModeAddr    = 2'd0;
  localparam logic [1:0] ModeInvAddr = 2'd1;
  localparam logic [1:0] ModeChecker = 2'd2;
  localparam logic [1:0] ModeWalkOne = 2'd3;

  // RAM driver geometry: one bank-select bit above a 20-bit SRAM word address
  localparam int unsigned SramAddrWidth = 20;
  localparam int unsigned BankSelBit    = SramAddrWidth;
  localparam int unsigned DrvAddrWidth  = SramAddrWidth + 1;
  localparam int unsigned DrvDataWidth  = 32;

endpackage

// File: rtl/ram_pattern_gen.sv
// Combinational test-pattern generator: maps a word address to its BIST data word.
module ram_pattern_gen
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_ext;
  logic [DATA_WIDTH-1:0]            addr_pat;
  logic [DATA_WIDTH-1:0]            check_pat;
  logic [DATA_WIDTH-1:0]            walk_pat;
  logic [ADDR_WIDTH-1:0]            bit_idx;

  // Padding first lets one slice cover both the zero-extend and truncate cases
  assign addr_ext = {{DATA_WIDTH{1'b0}}, addr};
  assign addr_pat = addr_ext[DATA_WIDTH-1:0];
  assign bit_idx  = addr % ADDR_WIDTH'(DATA_WIDTH);
  assign walk_pat = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_idx;

  // 0x5 nibbles on even addresses, 0xA nibbles on odd addresses
  always_comb begin
    check_pat = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      check_pat[i] = (i % 2 == 0) ? ~addr[0] : addr[0];
    end
  end

  // Pattern select
  always_comb begin
    case (mode)
      ModeAddr:    data = addr_pat;
      ModeInvAddr: data = ~addr_pat;
      ModeChecker: data = check_pat;
      ModeWalkOne: data = walk_pat;
      default:     data = addr_pat;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// RAM built-in self-test: writes a pattern over [addr_lo, addr_hi], reads it back and
// reports mismatches, with a per-response timeout.
module ram_bist
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ERR_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout_err,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  mem_read_req,
  output logic                  mem_write_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_write_done,
  input  logic                  mem_read_ready
);

  localparam int unsigned WaitWidth = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(TIMEOUT);

  logic [2:0]            state_q, state_d;
  logic                  start_q;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, cur_q, cur_d;
  logic [WaitWidth-1:0]  wait_q, wait_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pass_q, pass_d, tmo_q, tmo_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] fea_q, fea_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] fed_q, fed_d, mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] wr_pattern, exp_pattern;
  logic                  start_edge, range_err, last_addr, mismatch;

  assign start_edge = start & ~start_q;
  assign range_err  = lo_q > hi_q;
  assign last_addr  = cur_q == hi_q;
  assign mismatch   = rdata_q != exp_pattern;

  // Write data is generated for the address about to be requested
  ram_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_pattern (
    .mode (mode_d),
    .addr (cur_d),
    .data (wr_pattern)
  );

  ram_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_exp_pattern (
    .mode (mode_q),
    .addr (cur_q),
    .data (exp_pattern)
  );

  // Sequencer next-state and status updates
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cur_d   = cur_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    fea_d   = fea_q;
    fed_d   = fed_q;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StWrReq;
          mode_d  = mode;
          lo_d    = addr_lo;
          hi_d    = addr_hi;
          cur_d   = addr_lo;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          err_d   = '0;
          fea_d   = '0;
          fed_d   = '0;
        end
      end
      StWrReq: begin
        state_d = range_err ? StFinish : StWrWait;
        wait_d  = '0;
      end
      StWrWait: begin
        if (mem_write_done) begin
          if (last_addr) begin
            cur_d   = lo_q;
            state_d = StRdReq;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StWrReq;
          end
        end else if (wait_q == WaitMax) begin
          tmo_d   = 1'b1;
          state_d = StFinish;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRdReq: begin
        state_d = StRdWait;
        wait_d  = '0;
      end
      StRdWait: begin
        if (mem_read_ready) begin
          rdata_d = mem_rdata;
          state_d = StCheck;
        end else if (wait_q == WaitMax) begin
          tmo_d   = 1'b1;
          state_d = StFinish;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q == '0) begin
            fea_d = cur_q;
            fed_d = rdata_q;
          end
          if (!(&err_q)) err_d = err_q + 1'b1;
        end
        if (last_addr) begin
          // Settle pass on entry so it is already valid while done is high
          pass_d  = (err_d == '0) && !tmo_q;
          state_d = StFinish;
        end else begin
          cur_d   = cur_q + 1'b1;
          state_d = StRdReq;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Request address/data load together with the move into a request state
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == StWrReq || state_d == StRdReq) mem_addr_d = cur_d;
    if (state_d == StWrReq) mem_wdata_d = wr_pattern;
  end

  // State and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cur_q       <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      pass_q      <= 1'b0;
      tmo_q       <= 1'b0;
      err_q       <= '0;
      fea_q       <= '0;
      fed_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cur_q       <= cur_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      pass_q      <= pass_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      fea_q       <= fea_d;
      fed_q       <= fed_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy           = state_q != StIdle;
  assign done           = state_q == StFinish;
  assign mem_write_req  = (state_q == StWrReq) && !range_err;
  assign mem_read_req   = state_q == StRdReq;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign pass           = pass_q;
  assign timeout_err    = tmo_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural one-cycle-response memory model.
module tb_ram_bist;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] addr_lo = '0;
  logic [AW-1:0] addr_hi = '0;
  logic          busy, done, pass, timeout_err;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr, mem_addr;
  logic [DW-1:0] first_err_data, mem_wdata;
  logic          mem_read_req, mem_write_req;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_write_done = 1'b0;
  logic          mem_read_ready = 1'b0;

  ram_bist dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .addr_lo        (addr_lo),
    .addr_hi        (addr_hi),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_write_done (mem_write_done),
    .mem_read_ready (mem_read_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model controls and activity log
  bit            no_read = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int            cyc = 0, rd_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic          start_prev = 1'b0;
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];

  // Memory model: answers each request one cycle later; also logs DUT activity
  always @(posedge clk) begin
    mem_write_done <= 1'b0;
    mem_read_ready <= 1'b0;
    if (mem_write_req) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      mem_write_done <= 1'b1;
    end
    if (mem_read_req) begin
      rd_cnt++;
      rd_cyc = cyc;
      if (!no_read) begin
        mem_read_ready <= 1'b1;
        mem_rdata <= (corrupt_en && mem_addr == corrupt_addr) ? 32'h0000_DEAD : mem[mem_addr];
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start && !start_prev) start_cyc = cyc;
    start_prev = start;
    cyc++;
  end

  task automatic launch(input logic [1:0] m, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    @(negedge clk);
    mode = m;
    addr_lo = lo;
    addr_hi = hi;
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, pass, timeout_err} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, timeout_err}); end
    checks++; if ({mem_read_req, mem_write_req} !== 2'b0) begin errors++;
      $display("FAIL reset_req: got %b expected 00", {mem_read_req, mem_write_req}); end
    checks++; if (err_count !== '0 || first_err_addr !== '0 || first_err_data !== '0) begin
      errors++; $display("FAIL reset_err: got %h %h %h expected 0 0 0",
                         err_count, first_err_addr, first_err_data); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++;
      $display("FAIL reset_mem: got %h %h expected 0 0", mem_addr, mem_wdata); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen;
    launch(2'd0, 21'h10, 21'h13);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_done: got none expected pulse"); end
    checks++; if (wr_cnt != 4 || rd_cnt != 4) begin errors++;
      $display("FAIL basic_counts: got wr=%0d rd=%0d expected 4 4", wr_cnt, rd_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_data_log.size() <= i || wr_data_log[i] !== 32'h10 + i) begin errors++;
        $display("FAIL basic_wdata%0d: got %h expected %h", i,
                 (wr_data_log.size() > i) ? wr_data_log[i] : 'x, 32'h10 + i); end
    end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++;
      $display("FAIL basic_pulse: got done_cycles=%0d busy=%b expected 1 0", done_cnt, busy); end
    checks++; if (pass !== 1'b1 || err_count !== '0 || timeout_err !== 1'b0) begin errors++;
      $display("FAIL basic_status: got pass=%b err=%0d tmo=%b expected 1 0 0",
               pass, err_count, timeout_err); end
  endtask

  task automatic test_corrupt();
    bit seen;
    corrupt_en = 1'b1;
    corrupt_addr = 21'h12;
    launch(2'd1, 21'h10, 21'h13);
    wait_done(100, seen);
    corrupt_en = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL corrupt_done: got none expected pulse"); end
    checks++; if (wr_data_log.size() < 1 || wr_data_log[0] !== 32'hFFFF_FFEF) begin errors++;
      $display("FAIL corrupt_wdata: got %h expected ffffffef",
               (wr_data_log.size() > 0) ? wr_data_log[0] : 'x); end
    checks++; if (err_count !== 16'd1 || pass !== 1'b0) begin errors++;
      $display("FAIL corrupt_status: got err=%0d pass=%b expected 1 0", err_count, pass); end
    checks++; if (first_err_addr !== 21'h12 || first_err_data !== 32'h0000_DEAD) begin errors++;
      $display("FAIL corrupt_first: got %h %h expected 12 0000dead",
               first_err_addr, first_err_data); end
  endtask

  task automatic test_checker();
    bit seen;
    launch(2'd2, 21'h20, 21'h21);
    wait_done(100, seen);
    checks++; if (!seen || pass !== 1'b1) begin errors++;
      $display("FAIL checker_pass: got seen=%b pass=%b expected 1 1", seen, pass); end
    checks++; if (wr_data_log.size() != 2 || wr_data_log[0] !== 32'h5555_5555 ||
                  wr_data_log[1] !== 32'hAAAA_AAAA) begin errors++;
      $display("FAIL checker_wdata: got %0d words expected 55555555 aaaaaaaa", wr_data_log.size());
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int reqs;
    no_read = 1'b1;
    launch(2'd0, 21'h10, 21'h11);
    wait_done(400, seen);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_done: got none expected pulse"); end
    checks++; if (timeout_err !== 1'b1 || pass !== 1'b0) begin errors++;
      $display("FAIL timeout_status: got tmo=%b pass=%b expected 1 0", timeout_err, pass); end
    checks++; if (done_cyc - rd_cyc != 257) begin errors++;
      $display("FAIL timeout_latency: got %0d expected 257", done_cyc - rd_cyc); end
    reqs = wr_cnt + rd_cnt;
    repeat (20) @(negedge clk);
    checks++; if (wr_cnt + rd_cnt != reqs || rd_cnt != 1) begin errors++;
      $display("FAIL timeout_quiet: got reqs=%0d rd=%0d expected %0d 1", wr_cnt + rd_cnt,
               rd_cnt, reqs); end
    no_read = 1'b0;
  endtask

  task automatic test_top_range();
    bit seen;
    launch(2'd3, 21'h1F_FFFE, 21'h1F_FFFF);
    wait_done(100, seen);
    checks++; if (!seen || pass !== 1'b1) begin errors++;
      $display("FAIL top_pass: got seen=%b pass=%b expected 1 1", seen, pass); end
    checks++; if (wr_cnt != 2 || rd_cnt != 2) begin errors++;
      $display("FAIL top_counts: got wr=%0d rd=%0d expected 2 2", wr_cnt, rd_cnt); end
    checks++; if (wr_data_log.size() != 2 || wr_data_log[0] !== 32'h4000_0000 ||
                  wr_data_log[1] !== 32'h8000_0000) begin errors++;
      $display("FAIL top_wdata: got %0d words expected 40000000 80000000", wr_data_log.size()); end
    checks++; if (wr_addr_log.size() != 2 || wr_addr_log[1] !== 21'h1F_FFFF) begin errors++;
      $display("FAIL top_addr: got %0d addrs expected last 1fffff", wr_addr_log.size()); end
  endtask

  task automatic test_bad_range();
    bit seen;
    launch(2'd0, 21'd5, 21'd4);
    wait_done(20, seen);
    checks++; if (!seen || done_cyc - start_cyc != 2) begin errors++;
      $display("FAIL bad_latency: got seen=%b delay=%0d expected 1 2", seen, done_cyc - start_cyc);
    end
    checks++; if (pass !== 1'b0 || timeout_err !== 1'b0) begin errors++;
      $display("FAIL bad_status: got pass=%b tmo=%b expected 0 0", pass, timeout_err); end
    checks++; if (wr_cnt != 0 || rd_cnt != 0) begin errors++;
      $display("FAIL bad_reqs: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt); end
  endtask

  task automatic test_start_ignored();
    bit seen;
    launch(2'd0, 21'h30, 21'h31);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done(100, seen);
    repeat (20) @(negedge clk);
    checks++; if (!seen || done_cnt != 1 || wr_cnt != 2) begin errors++;
      $display("FAIL ignore_restart: got seen=%b dones=%0d wr=%0d expected 1 1 2",
               seen, done_cnt, wr_cnt); end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int reqs;
    launch(2'd0, 21'h10, 21'h13);
    for (int i = 0; i < 20 && !mem_write_req; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_write_req !== 1'b0 || mem_read_req !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got busy=%b wreq=%b rreq=%b expected 0 0 0",
                         busy, mem_write_req, mem_read_req); end
    reqs = wr_cnt + rd_cnt;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (done_cnt != 0 || wr_cnt + rd_cnt != reqs) begin errors++;
      $display("FAIL midrst_quiet: got dones=%0d reqs=%0d expected 0 %0d", done_cnt,
               wr_cnt + rd_cnt, reqs); end
    launch(2'd0, 21'h10, 21'h13);
    wait_done(100, seen);
    checks++; if (!seen || pass !== 1'b1 || wr_cnt != 4 || rd_cnt != 4) begin errors++;
      $display("FAIL midrst_rerun: got seen=%b pass=%b wr=%0d rd=%0d expected 1 1 4 4",
               seen, pass, wr_cnt, rd_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_checker();
    test_timeout();
    test_top_range();
    test_bad_range();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
